fp_mul: RTL and testbench



---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_mul_round.sv | 72 +++++++
 rtl/fp_mul.sv | 81 ++++++++
 tb/tb_fp_mul.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 field widths, constants and operand classification
// Provides: EXP_W, FRAC_W, BIAS, EXP_MAX, QNAN, POS_INF, fp_t unpack struct,
//           fp_class_e operand classes and fp_classify() helper.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Subnormals classify as zero: they are flushed before the multiply.
    function automatic fp_class_e fp_classify(input fp_t v);
        fp_class_e cls;
        if (v.exp == '0) begin
            cls = CLS_ZERO;
        end else if (v.exp == EXP_W'(EXP_MAX)) begin
            cls = (v.frac == '0) ? CLS_INF : CLS_NAN;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - normalize and round-to-nearest-even a 48b significand product
// Ports:
//   prod      in  48  product of two 24b significands (hidden ones included), value in [1,4)
//   exp_in    in  10  signed biased exponent eA + eB - BIAS before normalization
//   frac_out  out 23  rounded fraction field
//   exp_out   out  8  final biased exponent (valid only when neither flag is set)
//   overflow  out  1  final exponent >= EXP_MAX
//   underflow out  1  final exponent <= 0
module fp_mul_round
    import fp_pkg::*;
(
    input  logic [47:0]              prod,
    input  logic signed [9:0]        exp_in,
    output logic [FRAC_W-1:0]        frac_out,
    output logic [EXP_W-1:0]         exp_out,
    output logic                     overflow,
    output logic                     underflow
);

    logic [23:0]       mant;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              round_up;
    logic [24:0]       sum;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

    always_comb begin
        mant     = '0;
        guard    = 1'b0;
        rnd      = 1'b0;
        sticky   = 1'b0;
        exp_n    = exp_in;
        exp_r    = exp_in;
        frac_out = '0;

        // Product in [2,4): take the upper 24 bits and bump the exponent.
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            rnd    = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_in + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            rnd    = prod[21];
            sticky = |prod[20:0];
            exp_n  = exp_in;
        end

        // Ties (guard set, nothing below) round toward an even lsb.
        round_up = guard & (rnd | sticky | mant[0]);
        sum      = {1'b0, mant} + {24'd0, round_up};

        // Carry out of the significand means it became exactly 2.0;
        // the fraction is then all zeros and the exponent moves up by one.
        if (sum[24]) begin
            frac_out = sum[23:1];
            exp_r    = exp_n + 10'sd1;
        end else begin
            frac_out = sum[22:0];
            exp_r    = exp_n;
        end
    end

    assign overflow  = (exp_r >= 10'sd255);
    assign underflow = (exp_r <= 10'sd0);
    assign exp_out   = exp_r[EXP_W-1:0];

endmodule

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - registered IEEE-754 binary32 multiplier, RNE rounding, flush-to-zero
// Ports:
//   in_clk      in   1  clock, rising edge
//   in_rst_n    in   1  asynchronous active-low reset, clears out_result
//   in_numA     in  32  operand A (binary32)
//   in_numB     in  32  operand B (binary32)
//   out_result  out 32  A*B, registered, one cycle latency
module fp_mul
    import fp_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [31:0] in_numA,
    input  logic [31:0] in_numB,
    output logic [31:0] out_result
);

    fp_t               op_a;
    fp_t               op_b;
    fp_class_e         cls_a;
    fp_class_e         cls_b;
    logic              sign_r;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic [FRAC_W-1:0] rnd_frac;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_ovf;
    logic              rnd_unf;
    logic [31:0]       result_d;
    logic [31:0]       result_q;

    assign op_a   = fp_t'(in_numA);
    assign op_b   = fp_t'(in_numB);
    assign cls_a  = fp_classify(op_a);
    assign cls_b  = fp_classify(op_b);
    assign sign_r = op_a.sign ^ op_b.sign;

    assign prod    = {1'b1, op_a.frac} * {1'b1, op_b.frac};
    assign exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                   - $signed(10'(BIAS));

    fp_mul_round u_round (
        .prod      (prod),
        .exp_in    (exp_sum),
        .frac_out  (rnd_frac),
        .exp_out   (rnd_exp),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );

    // Special cases are resolved in priority order; the datapath result
    // from the rounder is only used when both operands are normal.
    always_comb begin
        result_d = {sign_r, rnd_exp, rnd_frac};
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            result_d = QNAN;
        end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            result_d = QNAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            result_d = {sign_r, POS_INF[30:0]};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            result_d = {sign_r, 31'd0};
        end else if (rnd_ovf) begin
            result_d = {sign_r, POS_INF[30:0]};
        end else if (rnd_unf) begin
            result_d = {sign_r, 31'd0};
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign out_result = result_q;

endmodule

// File: tb/tb_fp_mul.sv
// tb/tb_fp_mul.sv - scoreboard bench for fp_mul: directed vectors, async reset, random stream
module tb_fp_mul;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic [31:0] y;

    always #5 clk = ~clk;

    fp_mul dut (
        .in_clk     (clk),
        .in_rst_n   (rst_n),
        .in_numA    (a),
        .in_numB    (b),
        .out_result (y)
    );

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    task automatic apply(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ev);
        @(negedge clk);
        a = av;
        b = bv;
        exp_q.push_back(ev);
        name_q.push_back(nm);
    endtask

    // Independent integer reference for normal x normal operands.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] z);
        longint p, q, rem, half;
        int     e, sh;
        logic   s;
        s = x[31] ^ z[31];
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, z[22:0]});
        e = int'(x[30:23]) + int'(z[30:23]) - 127;
        if (p >= (64'sd1 <<< 47)) begin
            sh = 24;
            e++;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'sd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    // Monitor: one result per cycle, compared one sample after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                check(name_q.pop_front(), y, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        #12;
        check("reset_init", y, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        apply("mul_2x3",     32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        apply("mul_neg",     32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000);
        apply("mul_one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        apply("rnd_lsb",     32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        apply("rnd_carry",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
        apply("ovf",         32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
        apply("unf_pos",     32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        apply("unf_neg",     32'h8080_0000, 32'h0080_0000, 32'h8000_0000);
        apply("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        apply("nan_in",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        apply("neg_inf",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        apply("subnorm_ftz", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
        apply("neg_zero",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
        apply("nan_x_inf",   32'h7F80_0000, 32'hFFC0_0000, 32'h7FC0_0000);

        // Asynchronous reset between edges while a nonzero result is held.
        apply("pre_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", y, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_hold", y, 32'h0000_0000);
        @(negedge clk);
        a = 32'hBFC0_0000;
        b = 32'h4000_0000;
        exp_q.push_back(32'hC040_0000);
        name_q.push_back("post_rst");
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            apply($sformatf("rand_%0d", i), ra, rb, ref_mul(ra, rb));
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
